axis_addr_ram_frame: RTL and testbench
======================================

// Module: axis_addr_ram_frame
// PURPOSE
// - Parametrised AXI-Stream addressed RAM, next generation of the single-port stream RAM.
// - Slave stream delivers {address, data} write beats; s_axis_tlast closes a frame.
// - The block then drains the whole array, address 0..DEPTH-1, on the master stream with full
//   backpressure and m_axis_tlast.
// - Sits between a sample scatter source and a downstream streaming consumer.
// PARAMETERS
// - DATA_W   32   data word width (bits)
// - DEPTH    289  number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W
// - ADDR_W   9    address width carried on s_axis_tuser / m_axis_tuser
// - CNT_W    16   width of frame_cnt
// PORTS
// - aclk            in   1       clock, all logic on rising edge
// - aresetn         in   1       synchronous reset, active low
// - s_axis_tdata    in   DATA_W  write data
// - s_axis_tuser    in   ADDR_W  write address
// - s_axis_tlast    in   1       last write beat of frame
// - s_axis_tvalid   in   1       write beat valid
// - s_axis_tready   out  1       write beat accepted when valid&ready
// - m_axis_tdata    out  DATA_W  read data
// - m_axis_tuser    out  ADDR_W  address of m_axis_tdata
// - m_axis_tlast    out  1       high on the address DEPTH-1 beat
// - m_axis_tvalid   out  1       read beat valid
// - m_axis_tready   in   1       downstream ready
// - busy            out  1       high in INIT or DRAIN
// - addr_err        out  1       sticky: an accepted write had address >= DEPTH
// - frame_cnt       out  CNT_W   completed drains, wraps modulo 2**CNT_W
// BEHAVIOUR
// - Reset (aresetn=0 at a clock edge): state = LOAD (INIT if macro set).
//   - All outputs 0: s_axis_tready, m_axis_*, busy, addr_err, frame_cnt.
//   - s_axis_tready is forced 0 in any cycle aresetn=0.
// - LOAD: s_axis_tready=1, busy=0; each handshake writes mem[tuser]<=tdata.
//   - Same address twice in one frame: last write wins.
//   - tuser >= DEPTH: beat accepted, write dropped, addr_err<=1.
// - LOAD->DRAIN: on the handshake of a beat with tlast=1 (even if that write is dropped).
//   - s_axis_tready=0 from the next cycle.
// - DRAIN latency: tlast accepted at edge N; m_axis_tvalid=1 with addr 0 visible after edge N+2.
// - DRAIN throughput: 1 beat/cycle while m_axis_tready=1; registered read plus 2-entry skid.
// - AXIS master rules:
//   - While tvalid=1 and tready=0, tdata/tuser/tlast hold stable and tvalid stays 1.
//   - tvalid never depends combinationally on tready.
// - Drain ordering: addresses strictly 0,1,...,DEPTH-1, no gaps or repeats; tlast=1 only with
//   tuser=DEPTH-1.
// - DRAIN->LOAD: on the handshake of the tlast beat.
//   - Next cycle: s_axis_tready=1, m_axis_tvalid=0, frame_cnt+=1.
// - Memory keeps contents across frames unless AXIS_RAM_CLEAR_EN is defined.
// - Reset mid-DRAIN: beat in flight discarded, m_axis_tvalid=0 next cycle, read pointer=0,
//   frame_cnt not incremented.
// - Widths: read pointer ADDR_W bits, compared to DEPTH-1 explicitly, no modulo on
//   non-power-of-2 DEPTH.
// CONFIGURATION
// - AXIS_RAM_CLEAR_EN defined:
//   - After reset, state INIT writes 0 to mem[0..DEPTH-1], one per cycle (DEPTH cycles).
//   - During INIT: s_axis_tready=0, busy=1; then LOAD.
//   - In DRAIN, each location is written 0 in the cycle its beat handshakes, so the next frame
//     starts from all-zero.
// - AXIS_RAM_CLEAR_EN undefined:
//   - No INIT state; LOAD is entered directly from reset.
//   - Memory is not initialised; unwritten words read X in sim.
//   - Drained data persists.
// TESTING (DEPTH=8, ADDR_W=3 unless stated)
// - Write addr k <- 0x100+k for k=0..7, tlast on k=7, tready=1 ->
//   - out 0x100..0x107, tuser 0..7, tlast only on beat 7.
//   - frame_cnt=1; s_axis_tready=1 after last handshake.
// - Same frame, m_axis_tready toggled 1-0-0-1 pattern ->
//   - identical 8-beat sequence, outputs stable while stalled, no beat lost or repeated.
// - Write addr 3 <- 0xA then addr 3 <- 0xB, tlast ->
//   - beat tuser=3 carries 0xB (last write wins).
// - DEPTH=6: write addr 7 <- 0xDEAD with tlast ->
//   - addr_err=1, no memory change, drain of 6 beats tlast on tuser=5.
// - aresetn=0 for 1 cycle during beat 4 of a drain ->
//   - m_axis_tvalid=0, s_axis_tready=1 one cycle after release, frame_cnt=0.
//   - With CLEAR_EN: 8 INIT cycles precede tready=1.
// - With AXIS_RAM_CLEAR_EN: frame 1 writes all 8 addresses; frame 2 writes only addr 2 <- 0x55 ->
//   - frame 2 output 0,0,0x55,0,0,0,0,0.

Source files
------------

// File: rtl/axis_addr_ram_frame.sv
// axis_addr_ram_frame: framed, addressed AXI-Stream RAM.
//   A slave beat writes its tdata to mem[tuser]. A beat with tlast closes the
//   frame. The whole array is then drained in address order 0..DEPTH-1 on the
//   master stream, with full backpressure and tlast on the final word.
//
// Optional feature: define AXIS_RAM_CLEAR_EN to zero the array after reset
//   (INIT state, DEPTH cycles). With it, each word is also zeroed as its beat
//   is drained, so every frame starts from an all-zero array.
//
// Ports:
//   aclk, aresetn                  clock; synchronous active-low reset
//   s_axis_t{data,user,last,valid,ready}   write beats {addr=tuser, data}
//   m_axis_t{data,user,last,valid,ready}   drained words, tuser = address
//   busy                           high during INIT or DRAIN
//   addr_err                       sticky: an accepted write had tuser >= DEPTH
//   frame_cnt                      completed drains, wraps
module axis_addr_ram_frame #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 289,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [ADDR_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [ADDR_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              addr_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_INIT} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } beat_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic              rdy_q, busy_q, err_q;
  logic [CNT_W-1:0]  frame_q;
  logic [ADDR_W-1:0] rd_ptr;
  logic              issue_done;
  logic              r_vld;
  logic [ADDR_W-1:0] r_addr;
  logic              r_last;
  logic [DATA_W-1:0] r_data;
  beat_t             f0, f1;       // 2-entry skid, f0 is the output head
  logic [1:0]        f_cnt;
`ifdef AXIS_RAM_CLEAR_EN
  logic [ADDR_W-1:0] init_ptr;
`endif

  logic              s_hs, m_hs, in_range, issue;
  logic [2:0]        f_nxt;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  assign s_axis_tready = rdy_q & aresetn;
  assign m_axis_tvalid = (f_cnt != 2'd0);
  assign m_axis_tdata  = f0.data;
  assign m_axis_tuser  = f0.addr;
  assign m_axis_tlast  = f0.last;
  assign busy          = busy_q;
  assign addr_err      = err_q;
  assign frame_cnt     = frame_q;

  assign s_hs     = s_axis_tvalid & s_axis_tready;
  assign m_hs     = m_axis_tvalid & m_axis_tready;
  assign in_range = ({1'b0, s_axis_tuser} < DEPTH_X);

  // Skid occupancy after this edge; a new read may only be issued if the
  // word it returns next cycle still fits in the two entries.
  assign f_nxt = {1'b0, f_cnt} + {2'b0, r_vld} - {2'b0, m_hs};
  assign issue = (state == S_DRAIN) && !issue_done && (f_nxt < 3'd2);

  // Single write port: frame writes, plus zeroing when the clear feature is on.
  always_comb begin
    we = s_hs & in_range;
    wa = s_axis_tuser;
    wd = s_axis_tdata;
`ifdef AXIS_RAM_CLEAR_EN
    if (state == S_INIT) begin
      we = 1'b1;
      wa = init_ptr;
      wd = '0;
    end else if (state == S_DRAIN) begin
      we = m_hs;
      wa = m_axis_tuser;
      wd = '0;
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (we) mem[wa] <= wd;
    if (issue) r_data <= mem[rd_ptr];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
`ifdef AXIS_RAM_CLEAR_EN
      state    <= S_INIT;
      init_ptr <= '0;
`else
      state    <= S_LOAD;
`endif
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      frame_q    <= '0;
      rd_ptr     <= '0;
      issue_done <= 1'b0;
      r_vld      <= 1'b0;
      r_addr     <= '0;
      r_last     <= 1'b0;
      f0         <= '0;
      f1         <= '0;
      f_cnt      <= 2'd0;
    end else begin
      if (s_hs && !in_range) err_q <= 1'b1;

      // read issue stage
      r_vld <= issue;
      if (issue) begin
        r_addr <= rd_ptr;
        r_last <= (rd_ptr == LAST);
        if (rd_ptr == LAST) issue_done <= 1'b1;
        else                rd_ptr     <= rd_ptr + ADDR_W'(1);
      end

      // skid: pop shifts f1 to the head, returning read fills the first free slot
      f_cnt <= f_nxt[1:0];
      if (m_hs) f0 <= f1;
      if (r_vld) begin
        if (f_cnt == 2'd0 || (f_cnt == 2'd1 && m_hs)) f0 <= '{r_data, r_addr, r_last};
        else                                          f1 <= '{r_data, r_addr, r_last};
      end

      case (state)
`ifdef AXIS_RAM_CLEAR_EN
        S_INIT: begin
          init_ptr <= init_ptr + ADDR_W'(1);
          if (init_ptr == LAST) begin
            state  <= S_LOAD;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            busy_q <= 1'b1;
          end
        end
`endif
        S_LOAD: begin
          if (s_hs && s_axis_tlast) begin
            state  <= S_DRAIN;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
          end else begin
            rdy_q  <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (m_hs && m_axis_tlast) begin
            state      <= S_LOAD;
            rdy_q      <= 1'b1;
            busy_q     <= 1'b0;
            frame_q    <= frame_q + CNT_W'(1);
            rd_ptr     <= '0;
            issue_done <= 1'b0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_addr_ram_frame.sv
// Directed bench: DUT 0 has DEPTH=8, DUT 1 has DEPTH=6 (both ADDR_W=3).
module tb_axis_addr_ram_frame;

  logic        clk = 1'b0;
  logic        rstn    [2];
  logic [31:0] s_tdata [2];
  logic [2:0]  s_tuser [2];
  logic        s_tlast [2];
  logic        s_tvalid[2];
  logic        s_tready[2];
  logic [31:0] m_tdata [2];
  logic [2:0]  m_tuser [2];
  logic        m_tlast [2];
  logic        m_tvalid[2];
  logic        m_tready[2];
  logic        busy    [2];
  logic        addr_err[2];
  logic [15:0] frame_cnt[2];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axis_addr_ram_frame #(.DATA_W(32), .DEPTH(8), .ADDR_W(3), .CNT_W(16)) u_d8 (
    .aclk(clk), .aresetn(rstn[0]),
    .s_axis_tdata(s_tdata[0]), .s_axis_tuser(s_tuser[0]), .s_axis_tlast(s_tlast[0]),
    .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tuser(m_tuser[0]), .m_axis_tlast(m_tlast[0]),
    .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .busy(busy[0]), .addr_err(addr_err[0]), .frame_cnt(frame_cnt[0]));

  axis_addr_ram_frame #(.DATA_W(32), .DEPTH(6), .ADDR_W(3), .CNT_W(16)) u_d6 (
    .aclk(clk), .aresetn(rstn[1]),
    .s_axis_tdata(s_tdata[1]), .s_axis_tuser(s_tuser[1]), .s_axis_tlast(s_tlast[1]),
    .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tuser(m_tuser[1]), .m_axis_tlast(m_tlast[1]),
    .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .busy(busy[1]), .addr_err(addr_err[1]), .frame_cnt(frame_cnt[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input int d, input logic [2:0] a, input logic [31:0] v, input logic l);
    int t = 0;
    @(negedge clk);
    s_tdata[d] = v; s_tuser[d] = a; s_tlast[d] = l; s_tvalid[d] = 1'b1;
    while (!s_tready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_tready[d]) chk("wr_timeout", {31'b0, s_tready[d]}, 32'd1);
    @(posedge clk);
    #1 s_tvalid[d] = 1'b0; s_tlast[d] = 1'b0;
  endtask

  task automatic frame(input int d, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) wr(d, 3'(k), base + 32'(k), k == n - 1);
  endtask

  // Accept n beats; stall=1 drives m_tready in a 1,0,0,1 pattern.
  task automatic drain(input int d, input int n, input logic [31:0] e [8],
                       input int stall, input logic [15:0] fexp);
    int got = 0, cyc = 0;
    logic pv = 1'b0, prdy = 1'b0, pl = 1'b0, rdy;
    logic [31:0] pd = '0;
    logic [2:0] pu = '0;
    while (got < n && cyc < 300) begin
      @(negedge clk);
      if (pv && !prdy) begin
        chk($sformatf("d%0d_hold_v", d), {31'b0, m_tvalid[d]}, 32'd1);
        chk($sformatf("d%0d_hold_d", d), m_tdata[d], pd);
        chk($sformatf("d%0d_hold_u", d), {29'b0, m_tuser[d]}, {29'b0, pu});
        chk($sformatf("d%0d_hold_l", d), {31'b0, m_tlast[d]}, {31'b0, pl});
      end
      rdy = (stall == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      m_tready[d] = rdy;
      if (m_tvalid[d] && rdy) begin
        chk($sformatf("d%0d_data%0d", d, got), m_tdata[d], e[got]);
        chk($sformatf("d%0d_user%0d", d, got), {29'b0, m_tuser[d]}, 32'(got));
        chk($sformatf("d%0d_last%0d", d, got), {31'b0, m_tlast[d]}, {31'b0, got == n - 1});
        got++;
      end
      pv = m_tvalid[d]; pd = m_tdata[d]; pu = m_tuser[d]; pl = m_tlast[d]; prdy = rdy;
      cyc++;
    end
    if (got < n) chk($sformatf("d%0d_drain_timeout", d), 32'(got), 32'(n));
    @(negedge clk);
    m_tready[d] = 1'b0;
    chk($sformatf("d%0d_post_vld", d), {31'b0, m_tvalid[d]}, 32'd0);
    chk($sformatf("d%0d_post_srdy", d), {31'b0, s_tready[d]}, 32'd1);
    chk($sformatf("d%0d_post_busy", d), {31'b0, busy[d]}, 32'd0);
    chk($sformatf("d%0d_frame_cnt", d), {16'b0, frame_cnt[d]}, {16'b0, fexp});
  endtask

  logic [31:0] e [8];
  logic clr;

  initial begin
`ifdef AXIS_RAM_CLEAR_EN
    clr = 1'b1;
`else
    clr = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; s_tdata[d] = '0; s_tuser[d] = '0; s_tlast[d] = 1'b0;
      s_tvalid[d] = 1'b0; m_tready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_srdy", d), {31'b0, s_tready[d]}, 32'd0);
      chk($sformatf("d%0d_rst_mvld", d), {31'b0, m_tvalid[d]}, 32'd0);
      chk($sformatf("d%0d_rst_busy", d), {31'b0, busy[d]}, 32'd0);
      chk($sformatf("d%0d_rst_err", d), {31'b0, addr_err[d]}, 32'd0);
      chk($sformatf("d%0d_rst_fcnt", d), {16'b0, frame_cnt[d]}, 32'd0);
      rstn[d] = 1'b1;
    end

    // 1: straight frame, latency check, full-rate drain
    frame(0, 32'h100, 8);
    @(negedge clk);
    chk("lat_srdy_n1", {31'b0, s_tready[0]}, 32'd0);
    chk("lat_busy_n1", {31'b0, busy[0]}, 32'd1);
    chk("lat_vld_n1", {31'b0, m_tvalid[0]}, 32'd0);
    @(negedge clk);
    chk("lat_vld_n2", {31'b0, m_tvalid[0]}, 32'd0);
    @(negedge clk);
    chk("lat_vld_n3", {31'b0, m_tvalid[0]}, 32'd1);
    chk("lat_user_n3", {29'b0, m_tuser[0]}, 32'd0);
    for (int k = 0; k < 8; k++) e[k] = 32'h100 + 32'(k);
    drain(0, 8, e, 0, 16'd1);

    // 2: same frame, backpressured drain
    frame(0, 32'h100, 8);
    drain(0, 8, e, 1, 16'd2);

    // 3: last write wins on a repeated address
    wr(0, 3'd3, 32'hA, 1'b0);
    wr(0, 3'd3, 32'hB, 1'b1);
    for (int k = 0; k < 8; k++) e[k] = clr ? 32'h0 : 32'h100 + 32'(k);
    e[3] = 32'hB;
    drain(0, 8, e, 0, 16'd3);

    // 4: single-address frame; retained data vs cleared array
    wr(0, 3'd2, 32'h55, 1'b1);
    for (int k = 0; k < 8; k++) if (clr) e[k] = 32'h0;
    e[2] = 32'h55;
    drain(0, 8, e, 0, 16'd4);

    // 5: DEPTH=6, out-of-range address on the tlast beat
    frame(1, 32'h200, 6);
    for (int k = 0; k < 8; k++) e[k] = 32'h200 + 32'(k);
    drain(1, 6, e, 0, 16'd1);
    chk("d1_err_before", {31'b0, addr_err[1]}, 32'd0);
    wr(1, 3'd7, 32'hDEAD, 1'b1);
    chk("d1_err_after", {31'b0, addr_err[1]}, 32'd1);
    for (int k = 0; k < 8; k++) e[k] = clr ? 32'h0 : 32'h200 + 32'(k);
    drain(1, 6, e, 0, 16'd2);
    chk("d1_err_sticky", {31'b0, addr_err[1]}, 32'd1);

    // 6: reset during beat 4 of a drain
    frame(0, 32'h300, 8);
    begin
      int got = 0, cyc = 0;
      while (got < 4 && cyc < 100) begin
        @(negedge clk);
        m_tready[0] = 1'b1;
        if (m_tvalid[0]) begin
          chk($sformatf("rs_data%0d", got), m_tdata[0], 32'h300 + 32'(got));
          got++;
        end
        cyc++;
      end
      if (got < 4) chk("rs_timeout", 32'(got), 32'd4);
    end
    @(negedge clk);
    chk("rs_beat4_user", {29'b0, m_tuser[0]}, 32'd4);
    rstn[0] = 1'b0;
    m_tready[0] = 1'b0;
    chk("rs_srdy_forced", {31'b0, s_tready[0]}, 32'd0);
    @(negedge clk);
    chk("rs_vld_in_rst", {31'b0, m_tvalid[0]}, 32'd0);
    rstn[0] = 1'b1;
    @(negedge clk);
    chk("rs_vld_after", {31'b0, m_tvalid[0]}, 32'd0);
    chk("rs_fcnt_after", {16'b0, frame_cnt[0]}, 32'd0);
    if (clr) begin
      int k = 1;
      while (!s_tready[0] && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("rs_init_cycles", 32'(k), 32'd8);
    end else begin
      chk("rs_srdy_after", {31'b0, s_tready[0]}, 32'd1);
    end

    // 7: read pointer restarts at 0 after the reset
    frame(0, 32'h400, 8);
    for (int k = 0; k < 8; k++) e[k] = 32'h400 + 32'(k);
    drain(0, 8, e, 1, 16'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
